// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with byte-enable writeback, write-to-read bypass and busy-bit scoreboard
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 256,
  parameter int BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic                  rd_busy_a,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  output logic                  rd_busy_b,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  input  logic                  flush,
  output logic [ADDR_W:0]       pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_d;

  // Stored value merged with a same-cycle write on enabled lanes; r0 always reads as zero.
  function automatic logic [DATA_W:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              busy,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] d;
    logic              bz;
    d  = stored;
    bz = busy;
    if (BYPASS != 0 && we && wa == addr) begin
      bz = 1'b0;
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) d[8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (addr == '0) begin
      d  = '0;
      bz = 1'b0;
    end
    return {bz, d};
  endfunction

  // Next register contents: enabled byte lanes of the addressed register take wr_data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      for (int b = 0; b < BE_W; b++) begin
        if (i != 0 && wr_en && wr_addr == ADDR_W'(i) && wr_be[b]) begin
          regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Next busy bits: flush beats issue, a new producer beats writeback to the same register.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en && wr_addr != '0)       busy_d[wr_addr]    = 1'b0;
      if (issue_en && issue_addr != '0) busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy bits, registered so pend_cnt tracks busy_q.
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // State registers; reset clears everything except the stack pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_IDX && i != 0) ? DATA_W'(SP_INIT) : '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    {rd_busy_a, rd_data_a} = read_mux(rd_addr_a, regs_q[rd_addr_a], busy_q[rd_addr_a],
                                      wr_en, wr_addr, wr_data, wr_be);
    {rd_busy_b, rd_data_b} = read_mux(rd_addr_b, regs_q[rd_addr_b], busy_q[rd_addr_b],
                                      wr_en, wr_addr, wr_data, wr_be);
  end

  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb against an array-based reference model
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        flush;
  logic [5:0]  pend_cnt;

  typedef struct packed {
    logic [31:0] da;
    logic        ba;
    logic [31:0] db;
    logic        bb;
    logic [5:0]  pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] mreg [32];
  logic        mbusy[32];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_INIT(256), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .pend_cnt(pend_cnt)
  );

  // Reference read: stored value, overridden per lane by an in-flight write to the same register.
  function automatic logic [32:0] mread(input logic [4:0] a);
    logic [31:0] d;
    logic        bz;
    if (a == 5'd0) return 33'd0;
    d  = mreg[a];
    bz = mbusy[a];
    if (wr_en && wr_addr == a) begin
      bz = 1'b0;
      for (int b = 0; b < 4; b++) if (wr_be[b]) d[8*b +: 8] = wr_data[8*b +: 8];
    end
    return {bz, d};
  endfunction

  function automatic logic [5:0] mcount();
    int c = 0;
    for (int i = 0; i < 32; i++) if (mbusy[i]) c++;
    return 6'(c);
  endfunction

  function automatic void push_exp();
    exp_t e;
    {e.ba, e.da} = mread(rd_addr_a);
    {e.bb, e.db} = mread(rd_addr_b);
    e.pc = mcount();
    exp_q.push_back(e);
  endfunction

  function automatic void mclear();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'd0;
      mbusy[i] = 1'b0;
    end
    mreg[29] = 32'd256;
  endfunction

  // Apply the rising-edge rules to the model using the inputs held across the edge.
  function automatic void medge();
    if (wr_en && wr_addr != 5'd0)
      for (int b = 0; b < 4; b++) if (wr_be[b]) mreg[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
    if (flush) begin
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    end else begin
      if (wr_en && wr_addr != 5'd0)       mbusy[wr_addr]    = 1'b0;
      if (issue_en && issue_addr != 5'd0) mbusy[issue_addr] = 1'b1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  // Monitor: every falling edge, compare outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("rd_data_a", rd_data_a, mon_e.da);
      chk("rd_busy_a", {31'd0, rd_busy_a}, {31'd0, mon_e.ba});
      chk("rd_data_b", rd_data_b, mon_e.db);
      chk("rd_busy_b", {31'd0, rd_busy_b}, {31'd0, mon_e.bb});
      chk("pend_cnt", {26'd0, pend_cnt}, {26'd0, mon_e.pc});
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic ie, input logic [4:0] ia,
                       input logic fl, input logic [4:0] ra, input logic [4:0] rb);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    issue_en = ie; issue_addr = ia; flush = fl;
    rd_addr_a = ra; rd_addr_b = rb;
    push_exp();
    @(posedge clk);
    medge();
    #1;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    drive(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, ra, rb);
  endtask

  // Reset asserted between edges and checked at the falling edge before any rising edge.
  task automatic do_reset();
    reset = 1'b0;
    mclear();
    push_exp();
    @(negedge clk);
    #1;
    reset = 1'b1;
    wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; wr_be = 4'd0;
    issue_en = 1'b0; issue_addr = 5'd0; flush = 1'b0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd29;
    do_reset();

    drive(1'b1, 5'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    drive(1'b1, 5'd5, 32'h11223344, 4'b0101, 1'b0, 5'd0, 1'b0, 5'd5, 5'd29);
    idle(5'd5, 5'd5);

    drive(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
    idle(5'd7, 5'd0);
    drive(1'b1, 5'd7, 32'hCAFEF00D, 4'b1111, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);

    drive(1'b1, 5'd9, 32'h00000099, 4'b1111, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
    idle(5'd9, 5'd9);
    drive(1'b1, 5'd4, 32'h00000055, 4'b1111, 1'b1, 5'd3, 1'b1, 5'd4, 5'd3);
    idle(5'd4, 5'd3);

    drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    for (int i = 1; i < 32; i++)
      drive(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'(i), 1'b0, 5'(i), 5'(i - 1));
    idle(5'd31, 5'd1);
    idle(5'd5, 5'd9);

    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h12345678; wr_be = 4'b1111;
    issue_en = 1'b1; issue_addr = 5'd11; rd_addr_a = 5'd29; rd_addr_b = 5'd11;
    do_reset();
    idle(5'd10, 5'd5);
    idle(5'd29, 5'd11);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, ra, rb;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      drive(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom), 5'($urandom),
            ($urandom_range(0, 15) == 0), ra, rb);
    end
    idle(5'd1, 5'd2);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
